// File: rtl/dma_sector_mover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dma_sector_mover: packs the data_io byte stream into big-endian words and |
// | writes them to ST RAM via a req/ack port, tracking address and sectors.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dma_sector_mover #(
    parameter int FIFO_DEPTH   = 8,
    parameter int SECTOR_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] base,
    input  logic [7:0]  scnt,
    input  logic [7:0]  byte_in,
    input  logic        byte_strobe,
    output logic        byte_ready,
    output logic        mem_req,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic [23:0] cur_addr,
    output logic [7:0]  sectors_left,
    output logic        overrun
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SW_W  = $clog2(SECTOR_WORDS);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [SW_W-1:0] LAST_SW  = SW_W'(SECTOR_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [22:0]       word_addr_q, word_addr_d;
    logic [7:0]        sectors_q, sectors_d;
    logic [16:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic              odd_q, odd_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_req_q, mem_req_d;
    logic [SW_W-1:0]   sw_cnt_q, sw_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic [15:0]       fifo_mem_q [FIFO_DEPTH];

    logic fifo_full;
    logic accept;
    logic push;
    logic pop;
    logic unused_base0;

    assign unused_base0 = base[0];
    assign fifo_full    = (cnt_q == FULL_CNT);
    assign byte_ready   = (state_q == S_RUN) && !fifo_full;
    assign accept       = byte_ready && byte_strobe;
    // A word is complete on the second byte of each pair.
    assign push         = accept && odd_q;
    assign pop          = mem_req_q && mem_ack;

    assign mem_req      = mem_req_q;
    assign mem_addr     = word_addr_q;
    assign mem_data     = fifo_mem_q[rd_ptr_q];
    assign busy         = busy_q;
    assign done         = done_q;
    assign cur_addr     = {word_addr_q, 1'b0};
    assign sectors_left = sectors_q;
    assign overrun      = overrun_q;

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        sectors_d   = sectors_q;
        byte_cnt_d  = byte_cnt_q;
        hi_d        = hi_q;
        odd_d       = odd_q;
        overrun_d   = overrun_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sw_cnt_d    = sw_cnt_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d       = cnt_q;
        // Request drops the cycle after an ack, enforcing an idle gap between writes.
        mem_req_d   = mem_req_q ? !mem_ack : (cnt_q != '0);

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
            default: cnt_d = cnt_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_addr_d = base[23:1];
                    sectors_d   = scnt;
                    byte_cnt_d  = {scnt, 9'd0};
                    overrun_d   = 1'b0;
                    odd_d       = 1'b0;
                    sw_cnt_d    = '0;
                    busy_d      = 1'b1;
                    state_d     = (scnt == 8'd0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (byte_strobe && fifo_full) begin
                    overrun_d = 1'b1;
                end
                if (accept) begin
                    byte_cnt_d = byte_cnt_q - 17'd1;
                    odd_d      = !odd_q;
                    if (!odd_q) begin
                        hi_d = byte_in;
                    end
                    if (byte_cnt_q == 17'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0 && !mem_req_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            word_addr_d = word_addr_q + 23'd1;
            sw_cnt_d    = (sw_cnt_q == LAST_SW) ? '0 : sw_cnt_q + SW_W'(1);
            if (sw_cnt_q == LAST_SW) begin
                sectors_d = sectors_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            word_addr_q <= '0;
            sectors_q   <= '0;
            byte_cnt_q  <= '0;
            hi_q        <= '0;
            odd_q       <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            sw_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            sectors_q   <= sectors_d;
            byte_cnt_q  <= byte_cnt_d;
            hi_q        <= hi_d;
            odd_q       <= odd_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            sw_cnt_q    <= sw_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= {hi_q, byte_in};
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/dma_sector_mover.md
Name: dma_sector_mover

Overview:
- Data-path stage directly downstream of the DMA/FDC register block.
- When a sector read is started, it takes the programmed DMA base address and sector count.
- It takes the byte stream arriving from the ARM controller (data_io SPI side), packs bytes into big-endian 16-bit words and buffers them in a small FIFO.
- It writes each word to ST RAM through a request/acknowledge bus port, advancing the address.
- It reports progress and completion back to the register block.

Parameters:
FIFO_DEPTH, 8, word FIFO depth; power of two, minimum 2
SECTOR_WORDS, 256, 16-bit words per sector (512 bytes)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; latches base/scnt and begins a transfer
base  input  24  DMA byte start address; bit 0 ignored
scnt  input  8  number of sectors to transfer
byte_in  input  8  data byte from data_io
byte_strobe  input  1  one-cycle pulse; byte_in valid
byte_ready  output  1  engine can accept a byte this cycle
mem_req  output  1  write request to RAM arbiter
mem_addr  output  23  word address of current write
mem_data  output  16  word being written
mem_ack  input  1  one-cycle pulse; current write completed
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at transfer completion
cur_addr  output  24  byte address of next word to be written (bit 0 = 0)
sectors_left  output  8  sectors not yet fully written to RAM
overrun  output  1  sticky; byte arrived while FIFO full

Behaviour:
- Reset (asynchronous, reset=0):
  - State machine goes to IDLE.
  - All outputs 0; FIFO and counters cleared.
  - mem_req drops immediately, also when reset arrives mid-transfer.
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE:
  - On start: latch base[23:1] into the word address; set sectors_left=scnt.
  - Set the byte counter to scnt*512. The counter is 17 bits and holds values up to 130560.
  - Clear overrun and the packer; set busy=1.
  - Go to FINISH if scnt==0, else RUN.
- RUN:
  - Each byte_strobe with byte_ready=1 is accepted and decrements the byte counter.
  - Even-numbered byte (first, third, ...) goes to the high holding register.
  - The following byte forms the word {high, byte_in}, which is pushed into the FIFO in the same cycle.
  - When the byte counter reaches 0, go to DRAIN.
- DRAIN:
  - Ignore further byte_strobe; byte_ready=0.
  - When the FIFO is empty and no write is outstanding, go to FINISH.
- FINISH:
  - One cycle: done=1, busy=0; next state IDLE.
- byte_ready = (state==RUN) && FIFO not full. A strobe while FIFO full in RUN drops the byte, sets overrun=1 and does not decrement the counter.
- start while busy=1 is ignored.
- Memory port:
  - mem_req rises one cycle after the FIFO becomes non-empty.
  - mem_addr and mem_data come from the FIFO head and the address register, and stay stable while mem_req=1.
  - On mem_ack: pop the FIFO and increment the word address by 1, wrapping 23'h7FFFFF to 0.
  - mem_req deasserts for at least one cycle between writes, so back-to-back throughput is at most one word per 2 cycles.
  - mem_ack while mem_req=0 is ignored.
- cur_addr = {word_addr, 1'b0}.
- sectors_left decrements by 1 on the mem_ack that completes each SECTOR_WORDS-th word.
- Simultaneous FIFO push (byte pair completes) and pop (mem_ack) in one cycle: count unchanged, both data paths valid. A push into a full FIFO cannot happen because byte_ready gates it.
- The FIFO has no reset-preserving state; only the register block sees progress (cur_addr, sectors_left).

Test Plan:
- Reset mid-transfer: assert start (base=24'h010000, scnt=1), feed 100 bytes, pulse reset low → mem_req, busy, sectors_left, cur_addr all 0 immediately; state IDLE after release.
- Single sector: base=24'h010000, scnt=1, bytes 0x00..0xFF twice, mem_ack 2 cycles after each req → 256 writes.
  - First write: mem_addr=23'h008000, mem_data=16'h0001.
  - Last write: mem_addr=23'h0080FF, mem_data=16'hFEFF.
  - done pulses once; cur_addr=24'h010200; sectors_left=0.
- Zero count: start with scnt=0 → done pulses 2 cycles after start, no mem_req, cur_addr=base.
- Backpressure: FIFO_DEPTH=8, hold mem_ack low, stream bytes every cycle → byte_ready drops after 16 bytes.
  - A 17th strobe sets overrun=1.
  - After acks resume, exactly the first 16 bytes' words are written in order.
- Address wrap and multi-sector: base=24'hFFFE00, scnt=2 → words 0..255 go to 23'h7FFF00..23'h7FFFFF, next word to 23'h000000.
  - sectors_left steps 2→1→0.
  - Extra bytes strobed in DRAIN are ignored.
- start while busy: pulse start with different base mid-transfer → ignored; addresses continue from the original base.
